// File: rtl/seq_divider_if.sv
// Divider request/result bundle: operands and start in, status and results out.
// Combinational wires only; timing and handshake rules live in seq_divider.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; two's complement when SEQ_DIVIDER_SIGNED_EN is defined.
// Latency WIDTH+2 cycles incl. start cycle (2 on divide-by-zero); done is a one-cycle pulse.
// No backpressure: start is taken only in IDLE, ignored while busy; results hold until the next done.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave div_if
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmo_q, rmo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] q_fix, r_fix, dvd_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic ovfc_q, ovfc_d;
    logic ovf_q, ovf_d;

    assign op_a    = div_if.dividend[WIDTH-1] ? -div_if.dividend : div_if.dividend;
    assign op_b    = div_if.divisor[WIDTH-1]  ? -div_if.divisor  : div_if.divisor;
    assign q_fix   = qneg_q ? -dvd_q : dvd_q;
    assign r_fix   = rneg_q ? -rem_q : rem_q;
    assign dvd_fix = rneg_q ? -dvd_q : dvd_q;
`else
    assign op_a    = div_if.dividend;
    assign op_b    = div_if.divisor;
    assign q_fix   = dvd_q;
    assign r_fix   = rem_q;
    assign dvd_fix = dvd_q;
`endif

    // Difference only matters when there is no borrow, and is then < divisor, so WIDTH bits suffice.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign borrow  = shifted < {1'b0, dsr_q};
    assign diff    = shifted[WIDTH-1:0] - dsr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmo_d   = rmo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovfc_d  = ovfc_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    dvd_d   = op_a;
                    dsr_d   = op_b;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = (div_if.divisor == '0) ? FIXUP : DIVIDE;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    qneg_d  = div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1];
                    rneg_d  = div_if.dividend[WIDTH-1];
                    ovfc_d  = (div_if.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&div_if.divisor);
`endif
                end
            end
            DIVIDE: begin
                rem_d = borrow ? shifted[WIDTH-1:0] : diff;
                dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (dsr_q == '0) begin
                    quo_d = '1;
                    rmo_d = dvd_fix;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = q_fix;
                    rmo_d = r_fix;
                    dbz_d = 1'b0;
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                ovf_d   = ovfc_q;
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovfc_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmo_q   <= rmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovfc_q  <= ovfc_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.quotient    = quo_q;
    assign div_if.remainder   = rmo_q;
    assign div_if.div_by_zero = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    assign div_if.overflow    = ovf_q;
`else
    assign div_if.overflow    = 1'b0;
`endif
endmodule
